// File: rtl/wfc_pkg.sv
// Shared definitions for the weight fetch controller.
//   wfc_state_e  : FSM state encoding (IDLE, READ, WAIT, SERVE, DONE)
//   BW_8/BW_4/BW_2 : input_bitwidth encodings (2'b11 also selects 2-bit)
//   phase_count  : number of phases a 32-bit word is served for at a given bitwidth
package wfc_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StWait  = 3'd2,
    StServe = 3'd3,
    StDone  = 3'd4
  } wfc_state_e;

  localparam logic [1:0] BW_8 = 2'b00;
  localparam logic [1:0] BW_4 = 2'b01;
  localparam logic [1:0] BW_2 = 2'b10;

  // Phases per held word: 1 for 8b, 2 for 4b, 4 for 2b (both 10 and 11).
  function automatic logic [2:0] phase_count(input logic [1:0] bw);
    logic [2:0] p;
    p = 3'd4;
    if (bw == BW_8) begin
      p = 3'd1;
    end else if (bw == BW_4) begin
      p = 3'd2;
    end
    return p;
  endfunction

endpackage

// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: reads num_words consecutive words from the weight buffer starting
// at base_addr, holds each word in 'buffer' and steps 'state' through the phases the selected
// input bitwidth needs, one phase per out_valid/out_ready handshake.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   start, base_addr, num_words,
//   input_bitwidth              run request and its parameters (sampled with start in IDLE)
//   buf_rd_en, buf_addr         buffer read strobe / address
//   buf_rdata                   buffer read data, valid one cycle after buf_rd_en
//   buffer, state, out_valid    held word and phase index to the weight mux register
//   out_ready                   downstream accepts the buffer/state pair
//   busy, done                  run in progress / one-cycle end-of-run pulse
//   stall_cnt                   (only with WFC_STALL_CNT_EN) cycles with out_valid && !out_ready
//
// Optional feature macro: WFC_STALL_CNT_EN adds the saturating stall_cnt output.
module weight_fetch_ctrl
  import wfc_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic [1:0]        input_bitwidth,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [31:0]       buf_rdata,
  output logic [31:0]       buffer,
  output logic [1:0]        state,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
`ifdef WFC_STALL_CNT_EN
  output logic [CNT_W-1:0]  stall_cnt,
`endif
  output logic              done
);

  wfc_state_e        fsm_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;
  logic [1:0]        last_phase_q;
  logic [1:0]        phase_q;
  logic [31:0]       buffer_q;
  logic              rd_en_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;

  // Outputs are registered alongside the state: each transition sets the flags for the state
  // being entered, so buf_rd_en/out_valid/done line up with READ/SERVE/DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q        <= StIdle;
      addr_q       <= '0;
      remaining_q  <= '0;
      last_phase_q <= '0;
      phase_q      <= '0;
      buffer_q     <= '0;
      rd_en_q      <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (fsm_q)
        StIdle: begin
          if (start) begin
            addr_q       <= base_addr;
            remaining_q  <= num_words;
            last_phase_q <= 2'(phase_count(input_bitwidth) - 3'd1);
            busy_q       <= 1'b1;
            if (num_words == '0) begin
              fsm_q  <= StDone;
              done_q <= 1'b1;
            end else begin
              fsm_q   <= StRead;
              rd_en_q <= 1'b1;
            end
          end
        end
        StRead: begin
          fsm_q <= StWait;
        end
        StWait: begin
          buffer_q <= buf_rdata;
          phase_q  <= '0;
          valid_q  <= 1'b1;
          fsm_q    <= StServe;
        end
        StServe: begin
          if (out_ready) begin
            if (phase_q == last_phase_q) begin
              valid_q     <= 1'b0;
              addr_q      <= addr_q + 1'b1;  // wraps modulo 2^ADDR_W
              remaining_q <= remaining_q - 1'b1;
              if (remaining_q == CNT_W'(1)) begin
                fsm_q  <= StDone;
                done_q <= 1'b1;
              end else begin
                fsm_q   <= StRead;
                rd_en_q <= 1'b1;
              end
            end else begin
              phase_q <= phase_q + 1'b1;
            end
          end
        end
        StDone: begin
          busy_q <= 1'b0;
          fsm_q  <= StIdle;
        end
        default: begin
          fsm_q   <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign buf_rd_en = rd_en_q;
  assign buf_addr  = addr_q;
  assign buffer    = buffer_q;
  assign state     = phase_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef WFC_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (fsm_q == StIdle && start) begin
      stall_cnt_q <= '0;
    end else if (valid_q && !out_ready && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Self-checking bench for weight_fetch_ctrl: a per-cycle vector table covering several runs,
// followed by hand-written reset-abort and done-latency sequences.
module tb_weight_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [15:0] num_words;
  logic [1:0]  input_bitwidth;
  logic        buf_rd_en;
  logic [9:0]  buf_addr;
  logic [31:0] buf_rdata;
  logic [31:0] buffer;
  logic [1:0]  state;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
`ifdef WFC_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  weight_fetch_ctrl #(
    .ADDR_W(10),
    .CNT_W (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_words     (num_words),
    .input_bitwidth(input_bitwidth),
    .buf_rd_en     (buf_rd_en),
    .buf_addr      (buf_addr),
    .buf_rdata     (buf_rdata),
    .buffer        (buffer),
    .state         (state),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
`ifdef WFC_STALL_CNT_EN
    .stall_cnt     (stall_cnt),
`endif
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: word at address a is 0xAABBCC00 | a[7:0], one cycle read latency.
  always @(posedge clk) begin
    if (buf_rd_en) buf_rdata <= {24'hAABBCC, buf_addr[7:0]};
  end

  typedef struct {
    logic        s;
    logic [1:0]  bw;
    logic [9:0]  base;
    logic [15:0] nw;
    logic        rdy;
    logic        rd;
    logic [9:0]  addr;
    logic        v;
    logic [1:0]  st;
    logic [31:0] buff;
    logic        d;
    logic        b;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mk(input logic s, input logic [1:0] bw, input logic [9:0] base,
                              input logic [15:0] nw, input logic rdy, input logic rd,
                              input logic [9:0] addr, input logic v, input logic [1:0] st,
                              input logic [31:0] buff, input logic d, input logic b);
    vec_t r;
    r.s = s; r.bw = bw; r.base = base; r.nw = nw; r.rdy = rdy;
    r.rd = rd; r.addr = addr; r.v = v; r.st = st; r.buff = buff; r.d = d; r.b = b;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle-input row with given expected outputs.
  function automatic vec_t ex(input logic rd, input logic [9:0] addr, input logic v,
                              input logic [1:0] st, input logic [31:0] buff, input logic d,
                              input logic b);
    return mk(1'b0, 2'd0, 10'd0, 16'd0, 1'b1, rd, addr, v, st, buff, d, b);
  endfunction

  function automatic vec_t exr(input logic rdy, input logic [1:0] st, input logic [31:0] buff);
    return mk(1'b0, 2'd0, 10'd0, 16'd0, rdy, 1'b0, 10'd0, 1'b1, st, buff, 1'b0, 1'b1);
  endfunction

  initial begin
    logic [47:0] got_v, exp_v;
    int cyc;

    start = 0; base_addr = 0; num_words = 0; input_bitwidth = 0; out_ready = 1;
    reset = 1;
    step();
    step();
    chk("reset outputs", {buf_rd_en, buf_addr, buffer, state, out_valid, busy, done},
        64'd0);
    reset = 0;

    // A: 8b, base 5, 2 words, ready high: 3 cycles per word
    tbl.push_back(mk(1, 2'd0, 10'd5, 16'd2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(1, 10'd5, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 1, 2'd0, 32'hAABBCC05, 0, 1));
    tbl.push_back(ex(1, 10'd6, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 1, 2'd0, 32'hAABBCC06, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    // B: 4b, 1 word at 0xDD; inputs change and a stray start arrive mid-run
    tbl.push_back(mk(1, 2'd1, 10'd221, 16'd1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(1, 10'd221, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 2'd0, 10'd3, 16'd9, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(exr(1, 2'd0, 32'hAABBCCDD));
    tbl.push_back(exr(1, 2'd1, 32'hAABBCCDD));
    tbl.push_back(ex(0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    // C: zero words -> straight to DONE, no read
    tbl.push_back(mk(1, 2'd0, 10'd40, 16'd0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    // D: address wrap 1023 -> 0
    tbl.push_back(mk(1, 2'd0, 10'd1023, 16'd2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(1, 10'd1023, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 1, 2'd0, 32'hAABBCCFF, 0, 1));
    tbl.push_back(ex(1, 10'd0, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 1, 2'd0, 32'hAABBCC00, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 0));
    // E: 2b (encoding 11), 1 word at 3, ready low for 3 cycles on phase 2
    tbl.push_back(mk(1, 2'd3, 10'd3, 16'd1, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ex(1, 10'd3, 0, 0, 0, 0, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(exr(1, 2'd0, 32'hAABBCC03));
    tbl.push_back(exr(1, 2'd1, 32'hAABBCC03));
    tbl.push_back(exr(0, 2'd2, 32'hAABBCC03));
    tbl.push_back(exr(0, 2'd2, 32'hAABBCC03));
    tbl.push_back(exr(0, 2'd2, 32'hAABBCC03));
    tbl.push_back(exr(1, 2'd2, 32'hAABBCC03));
    tbl.push_back(exr(1, 2'd3, 32'hAABBCC03));
    tbl.push_back(ex(0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(ex(0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      start = tbl[i].s; input_bitwidth = tbl[i].bw; base_addr = tbl[i].base;
      num_words = tbl[i].nw; out_ready = tbl[i].rdy;
      got_v = {buf_rd_en, tbl[i].rd ? buf_addr : 10'd0, out_valid, tbl[i].v ? state : 2'd0,
               tbl[i].v ? buffer : 32'd0, done, busy};
      exp_v = {tbl[i].rd, tbl[i].rd ? tbl[i].addr : 10'd0, tbl[i].v,
               tbl[i].v ? tbl[i].st : 2'd0, tbl[i].v ? tbl[i].buff : 32'd0, tbl[i].d, tbl[i].b};
      chk($sformatf("row %0d {rd,addr,v,st,buf,done,busy}", i), 64'(got_v), 64'(exp_v));
      step();
    end
    start = 0; out_ready = 1;

`ifdef WFC_STALL_CNT_EN
    chk("stall_cnt after 3 stalled cycles", 64'(stall_cnt), 64'd3);
`endif

    // F: reset while in SERVE, with a start pulse issued while busy
    start = 1; input_bitwidth = 2'd0; base_addr = 10'd10; num_words = 16'd3;
    step();
    start = 0;
    chk("F read addr", {buf_rd_en, buf_addr}, {1'b1, 10'd10});
    step();
    start = 1; base_addr = 10'd100; num_words = 16'd0;
    step();
    start = 0; out_ready = 0;
    chk("F serve before reset", {out_valid, buffer, busy}, {1'b1, 32'hAABBCC0A, 1'b1});
    reset = 1;
    step();
    reset = 0; out_ready = 1;
    chk("F outputs after reset", {buf_rd_en, buf_addr, buffer, state, out_valid, busy, done},
        64'd0);
`ifdef WFC_STALL_CNT_EN
    chk("F stall_cnt after reset", 64'(stall_cnt), 64'd0);
`endif
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (done || busy || buf_rd_en || out_valid) cyc++;
    end
    chk("F no activity after abort", 64'(cyc), 64'd0);

    // G: 2b single word with ready high, done latency 1 + (P+2) = 7 cycles from start
    start = 1; input_bitwidth = 2'd2; base_addr = 10'd7; num_words = 16'd1;
    step();
    start = 0;
    cyc = 1;
    while (!done && cyc < 30) begin
      step();
      cyc++;
    end
    chk("G done latency", 64'(cyc), 64'd7);
    step();
    chk("G idle after done", {busy, done}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
